data_mem_responder: RTL and testbench

- Byte-addressed data memory that answers the multi-cycle CPU's memory-stage requests (mRD for lw, mWR for sw).
- Adds configurable wait states and a one-cycle `ready` completion pulse, so the control unit can stall in its MEM state until the access finishes.
- Words are stored big-endian in an 8-bit array.

---
 rtl/data_mem_responder.sv | 111 +++++++++++
 tb/tb_data_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory for the multi-cycle CPU's MEM stage.
// Each request runs through IDLE -> WAIT -> DONE. `ready` is a registered pulse issued at the access edge.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [CW-1:0]         cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  is_wr_r;
  logic                  reject_r;
  logic [7:0]            mem_r [0:DEPTH-1];
  logic                  unused_s;

  // Bits above the decoded range are deliberately ignored so addresses wrap.
  assign unused_s = ^addr[31:ADDR_WIDTH];

  // Index of byte `off` of the word at `base`, wrapping at the memory size.
  function automatic logic [ADDR_WIDTH-1:0] byte_idx(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [1:0] off);
    return base + ADDR_WIDTH'(off);
  endfunction

  // Request sequencing, wait-state counting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      rdata    <= 32'd0;
      ready    <= 1'b0;
      err      <= 1'b0;
      is_wr_r  <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mRD || mWR) begin
            addr_r   <= addr[ADDR_WIDTH-1:0];
            wdata_r  <= wdata;
            is_wr_r  <= mWR;
            // Conflicting op or misaligned word still completes, but flagged.
            reject_r <= (mRD && mWR) || (addr[1:0] != 2'b00);
            err      <= 1'b0;
            if (HAS_WAIT) begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          ready   <= 1'b1;
          err     <= reject_r;
          state_r <= ST_IDLE;
          if (!reject_r && !is_wr_r) begin
            rdata <= {mem_r[byte_idx(addr_r, 2'd0)], mem_r[byte_idx(addr_r, 2'd1)],
                      mem_r[byte_idx(addr_r, 2'd2)], mem_r[byte_idx(addr_r, 2'd3)]};
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array; contents survive reset, and only an unrejected write in DONE updates it.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ST_DONE && is_wr_r && !reject_r) begin
      mem_r[byte_idx(addr_r, 2'd0)] <= wdata_r[31:24];
      mem_r[byte_idx(addr_r, 2'd1)] <= wdata_r[23:16];
      mem_r[byte_idx(addr_r, 2'd2)] <= wdata_r[15:8];
      mem_r[byte_idx(addr_r, 2'd3)] <= wdata_r[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance driven by a vector table,
// plus a WAIT_CYCLES=0 instance and hand-written reset and back-to-back sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic mrd0, mwr0, ready0, err0;
  logic mrd1, mwr1, ready1, err1;
  logic [31:0] addr0, wdata0, rdata0;
  logic [31:0] addr1, wdata1, rdata1;

  int n_chk = 0;
  int n_fail = 0;

  data_mem_responder #(.ADDR_WIDTH(7), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .mRD(mrd0), .mWR(mwr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0)
  );

  data_mem_responder #(.ADDR_WIDTH(7), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .mRD(mrd1), .mWR(mwr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .err(err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      mrd1 = rd; mwr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      mrd0 = rd; mwr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ready1 : ready0;
  endfunction

  // Hold a request until ready, then drop it; lat counts edges from acceptance to ready.
  task automatic xact(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] q,
                      output logic e);
    set_req(sel, rd, wr, a, d);
    @(posedge clk); #1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy(sel)) break;
    end
    q = sel ? rdata1 : rdata0;
    e = sel ? err1 : err0;
    set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("ready_single_pulse", 32'(rdy(sel)), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    logic        e;
    int          hits[$];
    logic        saw_ready;

    vecs[0]  = '{"wr_08",       1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 3, 32'h00000000, 1'b0};
    vecs[1]  = '{"rd_08",       1'b1, 1'b0, 32'h08, 32'h0,        3, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"rd_misalign", 1'b1, 1'b0, 32'h0A, 32'h0,        3, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{"rd_clear_err",1'b1, 1'b0, 32'h08, 32'h0,        3, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{"wr_10",       1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 3, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{"conflict_10", 1'b1, 1'b1, 32'h10, 32'h12345678, 3, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{"rd_10_old",   1'b1, 1'b0, 32'h10, 32'h0,        3, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{"wr_80_wrap",  1'b0, 1'b1, 32'h80, 32'h0000000A, 3, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{"rd_00_wrap",  1'b1, 1'b0, 32'h00, 32'h0,        3, 32'h0000000A, 1'b0};
    vecs[9]  = '{"wr_7c",       1'b0, 1'b1, 32'h7C, 32'h55667788, 3, 32'h0000000A, 1'b0};
    vecs[10] = '{"rd_fc_high",  1'b1, 1'b0, 32'hFC, 32'h0,        3, 32'h55667788, 1'b0};
    vecs[11] = '{"wr_20",       1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 3, 32'h55667788, 1'b0};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rdata", rdata0, 32'd0);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_state", 32'(dut0.state_r), 32'd0);
    check("rst_rdata_w0", rdata1, 32'd0);
    check("rst_ready_w0", 32'(ready1), 32'd0);

    foreach (vecs[i]) begin
      xact(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, lat, q, e);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_rdata"}, q, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
    end
    check("mem_bytes_8_11", {dut0.mem_r[8], dut0.mem_r[9], dut0.mem_r[10], dut0.mem_r[11]},
          32'hDEADBEEF);

    // Reset during WAIT discards the pending write and suppresses ready.
    set_req(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_ready = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready0) saw_ready = 1'b1;
    end
    check("midrst_no_ready", 32'(saw_ready), 32'd0);
    check("midrst_rdata", rdata0, 32'd0);
    xact(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, lat, q, e);
    check("midrst_rd_20", q, 32'hA5A5A5A5);
    check("midrst_rd_lat", 32'(lat), 32'd3);

    // Zero wait states: ready one edge after acceptance.
    xact(1'b1, 1'b0, 1'b1, 32'h04, 32'h0BADF00D, lat, q, e);
    check("w0_wr_lat", 32'(lat), 32'd1);
    xact(1'b1, 1'b1, 1'b0, 32'h04, 32'd0, lat, q, e);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_data", q, 32'h0BADF00D);
    check("w0_rd_err", 32'(e), 32'd0);
    xact(1'b1, 1'b1, 1'b0, 32'h06, 32'd0, lat, q, e);
    check("w0_misalign_err", 32'(e), 32'd1);
    check("w0_misalign_rdata", q, 32'h0BADF00D);

    // A held write re-triggers every WAIT_CYCLES+2 edges.
    set_req(1'b0, 1'b0, 1'b1, 32'h40, 32'h01020304);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (ready0) hits.push_back(i);
    end
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("b2b_count", 32'(hits.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hits.size()) check($sformatf("b2b_edge%0d", i), 32'(hits[i]), 32'(3 + 4 * i));
    end
    saw_ready = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready0) saw_ready = 1'b1;
    end
    check("b2b_stops", 32'(saw_ready), 32'd0);
    xact(1'b0, 1'b1, 1'b0, 32'h40, 32'd0, lat, q, e);
    check("b2b_rd_40", q, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
